boruss_fetch_unit: RTL and testbench

Instruction fetch unit for the Boruss CPU. It drives the 8-bit address of the combinational program ROM and captures the returned byte. It assembles 1- or 2-byte instructions and hands them to decode/execute over a valid/ready handshake. It resolves unconditional JMP internally and accepts a PC redirect from execute for taken conditional branches.

---
 rtl/boruss_fetch_unit.sv | 117 +++++++++++
 tb/tb_boruss_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/boruss_fetch_unit.sv
// Boruss CPU instruction fetch unit: walks the combinational program ROM,
// assembles 1- or 2-byte instructions and presents them on a valid/ready port.
module boruss_fetch_unit #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         JMP_IN_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       fetch_en,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [3:0] instr_opcode,
    output logic [1:0] instr_dest,
    output logic [1:0] instr_src,
    output logic [7:0] instr_operand,
    output logic       instr_len2,
    output logic [7:0] instr_pc
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic       valid_q;
    logic [3:0] opcode_q;
    logic [1:0] dest_q;
    logic [1:0] src_q;
    logic [7:0] operand_q;
    logic       len2_q;
    logic [7:0] instrPc_q;

    logic [7:0] pcInc_d;
    logic       twoByte_d;

    // LOAD immediate (opcode 0, src 01) and the whole 1xxx jump family carry a second byte
    assign pcInc_d   = pc_q + 8'd1;
    assign twoByte_d = rom_data[7] || ((rom_data[7:4] == 4'b0000) && (rom_data[1:0] == 2'b01));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            opcode_q  <= 4'h0;
            dest_q    <= 2'b00;
            src_q     <= 2'b00;
            operand_q <= 8'h00;
            len2_q    <= 1'b0;
            instrPc_q <= 8'h00;
        end else if (redirect_valid) begin
            pc_q    <= redirect_addr;
            state_q <= FETCH_OP;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (fetch_en) begin
                        opcode_q  <= rom_data[7:4];
                        dest_q    <= rom_data[3:2];
                        src_q     <= rom_data[1:0];
                        len2_q    <= twoByte_d;
                        instrPc_q <= pc_q;
                        pc_q      <= pcInc_d;
                        if (twoByte_d) begin
                            state_q <= FETCH_IMM;
                        end else begin
                            operand_q <= 8'h00;
                            valid_q   <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (fetch_en) begin
                        operand_q <= rom_data;
                        if (JMP_IN_FETCH && (opcode_q == 4'b1000)) begin
                            pc_q    <= rom_data;
                            state_q <= FETCH_OP;
                        end else begin
                            pc_q    <= pcInc_d;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= FETCH_OP;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= FETCH_OP;
                end
            endcase
        end
    end

    assign rom_addr      = pc_q;
    assign instr_valid   = valid_q;
    assign instr_opcode  = opcode_q;
    assign instr_dest    = dest_q;
    assign instr_src     = src_q;
    assign instr_operand = operand_q;
    assign instr_len2    = len2_q;
    assign instr_pc      = instrPc_q;

endmodule

// File: tb/tb_boruss_fetch_unit.sv
// Directed bench for boruss_fetch_unit: three instances cover in-fetch JMP,
// emitted JMP and a reset PC at the top of the address space.
module tb_boruss_fetch_unit;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   acceptCount;

    logic [7:0] romA [256];
    logic [7:0] romW [256];

    // Instance A: defaults (RESET_PC=00, JMP resolved in fetch)
    logic [7:0] aRomAddr, aRomData, aRedirA, aOperand, aPc;
    logic       aFetchEn, aRedirV, aValid, aReady, aLen2;
    logic [3:0] aOpcode;
    logic [1:0] aDest, aSrc;

    // Instance N: JMP emitted like any other instruction
    logic [7:0] nRomAddr, nRomData, nRedirA, nOperand, nPc;
    logic       nFetchEn, nRedirV, nValid, nReady, nLen2;
    logic [3:0] nOpcode;
    logic [1:0] nDest, nSrc;

    // Instance W: RESET_PC=FF to exercise PC wrap
    logic [7:0] wRomAddr, wRomData, wRedirA, wOperand, wPc;
    logic       wFetchEn, wRedirV, wValid, wReady, wLen2;
    logic [3:0] wOpcode;
    logic [1:0] wDest, wSrc;

    assign aRomData = romA[aRomAddr];
    assign nRomData = romA[nRomAddr];
    assign wRomData = romW[wRomAddr];

    boruss_fetch_unit #(.RESET_PC(8'h00), .JMP_IN_FETCH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(aRomAddr), .rom_data(aRomData),
        .fetch_en(aFetchEn), .redirect_valid(aRedirV), .redirect_addr(aRedirA),
        .instr_valid(aValid), .instr_ready(aReady), .instr_opcode(aOpcode),
        .instr_dest(aDest), .instr_src(aSrc), .instr_operand(aOperand),
        .instr_len2(aLen2), .instr_pc(aPc)
    );

    boruss_fetch_unit #(.RESET_PC(8'h00), .JMP_IN_FETCH(1'b0)) dutN (
        .clk(clk), .rst_n(rst_n), .rom_addr(nRomAddr), .rom_data(nRomData),
        .fetch_en(nFetchEn), .redirect_valid(nRedirV), .redirect_addr(nRedirA),
        .instr_valid(nValid), .instr_ready(nReady), .instr_opcode(nOpcode),
        .instr_dest(nDest), .instr_src(nSrc), .instr_operand(nOperand),
        .instr_len2(nLen2), .instr_pc(nPc)
    );

    boruss_fetch_unit #(.RESET_PC(8'hFF), .JMP_IN_FETCH(1'b1)) dutW (
        .clk(clk), .rst_n(rst_n), .rom_addr(wRomAddr), .rom_data(wRomData),
        .fetch_en(wFetchEn), .redirect_valid(wRedirV), .redirect_addr(wRedirA),
        .instr_valid(wValid), .instr_ready(wReady), .instr_opcode(wOpcode),
        .instr_dest(wDest), .instr_src(wSrc), .instr_operand(wOperand),
        .instr_len2(wLen2), .instr_pc(wPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts completed handshakes on instance A, including one that coincides with a redirect
    always @(posedge clk) begin
        if (rst_n && aValid && aReady) acceptCount <= acceptCount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        acceptCount = 0;
        for (int i = 0; i < 256; i++) begin
            romA[i] = 8'h00;
            romW[i] = 8'h00;
        end
        romA[8'h00] = 8'h01;
        romA[8'h01] = 8'h01;
        for (int i = 2; i <= 8; i++) romA[i] = 8'h60;
        romA[8'h09] = 8'h80;
        romA[8'h0A] = 8'h00;
        romW[8'hFF] = 8'h01;
        romW[8'h00] = 8'h5A;

        rst_n = 1'b0;
        aFetchEn = 1'b1; aReady = 1'b1; aRedirV = 1'b0; aRedirA = 8'h00;
        nFetchEn = 1'b0; nReady = 1'b0; nRedirV = 1'b0; nRedirA = 8'h00;
        wFetchEn = 1'b0; wReady = 1'b0; wRedirV = 1'b0; wRedirA = 8'h00;

        applyStimulus(2);
        checkOutput("rst_addr", aRomAddr, 8'h00);
        checkOutput("rst_valid", 8'(aValid), 8'h00);
        checkOutput("rst_opcode", 8'(aOpcode), 8'h00);
        checkOutput("rst_operand", aOperand, 8'h00);
        checkOutput("rst_pc", aPc, 8'h00);
        checkOutput("rst_addr_w", wRomAddr, 8'hFF);
        rst_n = 1'b1;

        // LOAD immediate at 00/01
        step();
        checkOutput("ld_imm_addr", aRomAddr, 8'h01);
        checkOutput("ld_imm_valid", 8'(aValid), 8'h00);
        step();
        checkOutput("ld_valid", 8'(aValid), 8'h01);
        checkOutput("ld_opcode", 8'(aOpcode), 8'h00);
        checkOutput("ld_dest", 8'(aDest), 8'h00);
        checkOutput("ld_src", 8'(aSrc), 8'h01);
        checkOutput("ld_operand", aOperand, 8'h01);
        checkOutput("ld_len2", 8'(aLen2), 8'h01);
        checkOutput("ld_pc", aPc, 8'h00);
        step();
        checkOutput("ld_done_valid", 8'(aValid), 8'h00);
        checkOutput("ld_next_addr", aRomAddr, 8'h02);

        // First SHL, then stall for five cycles
        step();
        checkOutput("shl2_valid", 8'(aValid), 8'h01);
        checkOutput("shl2_opcode", 8'(aOpcode), 8'h06);
        checkOutput("shl2_operand", aOperand, 8'h00);
        checkOutput("shl2_len2", 8'(aLen2), 8'h00);
        checkOutput("shl2_pc", aPc, 8'h02);
        aReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_valid", 8'(aValid), 8'h01);
            checkOutput("stall_pc", aPc, 8'h02);
            checkOutput("stall_addr", aRomAddr, 8'h03);
        end
        aReady = 1'b1;
        step();
        checkOutput("shl2_acc_valid", 8'(aValid), 8'h00);
        for (int k = 3; k <= 8; k++) begin
            step();
            checkOutput("shl_valid", 8'(aValid), 8'h01);
            checkOutput("shl_pc", aPc, 8'(k));
            step();
            checkOutput("shl_gap", 8'(aValid), 8'h00);
        end

        // In-fetch JMP 09 -> 00
        step();
        checkOutput("jmp_imm_addr", aRomAddr, 8'h0A);
        checkOutput("jmp_imm_valid", 8'(aValid), 8'h00);
        step();
        checkOutput("jmp_target", aRomAddr, 8'h00);
        checkOutput("jmp_no_valid", 8'(aValid), 8'h00);

        // Redirect while in FETCH_IMM at 01
        step();
        checkOutput("redir_pre_addr", aRomAddr, 8'h01);
        aRedirV = 1'b1; aRedirA = 8'h40;
        step();
        aRedirV = 1'b0;
        checkOutput("redir_addr", aRomAddr, 8'h40);
        checkOutput("redir_valid", 8'(aValid), 8'h00);
        step();
        checkOutput("nop40_valid", 8'(aValid), 8'h01);
        checkOutput("nop40_pc", aPc, 8'h40);
        checkOutput("nop40_len2", 8'(aLen2), 8'h00);

        // Redirect in HOLD coinciding with an accept
        aRedirV = 1'b1; aRedirA = 8'h50;
        step();
        aRedirV = 1'b0;
        aFetchEn = 1'b0;
        checkOutput("hold_redir_addr", aRomAddr, 8'h50);
        checkOutput("hold_redir_valid", 8'(aValid), 8'h00);
        checkOutput("accept_count", 8'(acceptCount), 8'd9);

        // Emitted JMP on instance N
        nReady = 1'b1; nFetchEn = 1'b1; nRedirV = 1'b1; nRedirA = 8'h09;
        step();
        nRedirV = 1'b0;
        checkOutput("n_addr", nRomAddr, 8'h09);
        step();
        checkOutput("n_imm_valid", 8'(nValid), 8'h00);
        step();
        checkOutput("n_valid", 8'(nValid), 8'h01);
        checkOutput("n_opcode", 8'(nOpcode), 8'h08);
        checkOutput("n_operand", nOperand, 8'h00);
        checkOutput("n_len2", 8'(nLen2), 8'h01);
        checkOutput("n_pc", nPc, 8'h09);
        checkOutput("n_next_addr", nRomAddr, 8'h0B);

        // Wrap on instance W, with a freeze in FETCH_OP and FETCH_IMM
        step();
        checkOutput("w_freeze_op", wRomAddr, 8'hFF);
        wFetchEn = 1'b1;
        step();
        checkOutput("w_imm_addr", wRomAddr, 8'h00);
        wFetchEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("w_freeze_addr", wRomAddr, 8'h00);
            checkOutput("w_freeze_valid", 8'(wValid), 8'h00);
        end
        wFetchEn = 1'b1;
        step();
        checkOutput("w_valid", 8'(wValid), 8'h01);
        checkOutput("w_pc", wPc, 8'hFF);
        checkOutput("w_operand", wOperand, 8'h5A);
        checkOutput("w_src", 8'(wSrc), 8'h01);
        checkOutput("w_len2", 8'(wLen2), 8'h01);
        checkOutput("w_next_addr", wRomAddr, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
